// File: rtl/arb_sched_rr.sv
// Round-robin burst scheduler: one-beat slot per input port, merged registered output
// with grant held for up to MAX_BURST beats or until the holder goes quiet for HOLD_TIMEOUT cycles.
module arb_sched_rr #(
   parameter int NUM_PORTS    = 4,
   parameter int DATA_WIDTH   = 22,
   parameter int MAX_BURST    = 4,
   parameter int HOLD_TIMEOUT = 15
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [NUM_PORTS-1:0]            i_valid,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_PORTS-1:0]            i_last,
   output logic [NUM_PORTS-1:0]            o_ready,
   output logic                            o_valid,
   output logic [DATA_WIDTH-1:0]           o_data,
   output logic [$clog2(NUM_PORTS)-1:0]    o_port,
   output logic                            o_last,
   input  logic                            i_ready,
   output logic                            o_busy
);
   localparam int PW = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_reg, state_next;
   logic [PW-1:0]         ptr_reg, ptr_next;
   logic [PW-1:0]         gnt_reg, gnt_next;
   logic [3:0]            cnt_reg, cnt_next;
   logic [7:0]            idle_reg, idle_next;
   logic [NUM_PORTS-1:0]  full_reg, full_next;
   logic [NUM_PORTS-1:0]  slot_last_reg;
   logic [DATA_WIDTH-1:0] slot_data_reg [NUM_PORTS];

   logic                  valid_next, last_next;
   logic [DATA_WIDTH-1:0] data_next;
   logic [PW-1:0]         port_next;
   logic                  out_free, load;
   logic [PW-1:0]         src, sel, scan_idx;
   logic                  sel_found;

   assign out_free = ~o_valid | i_ready;
   assign o_ready  = ~full_reg;
   assign o_busy   = (state_reg == BURST);

   // First full slot after the last granted port, wrapping around.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      scan_idx  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         scan_idx = PW'((int'(ptr_reg) + k) % NUM_PORTS);
         if (!sel_found && full_reg[scan_idx]) begin
            sel       = scan_idx;
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      gnt_next   = gnt_reg;
      cnt_next   = cnt_reg;
      idle_next  = idle_reg;
      valid_next = o_valid;
      data_next  = o_data;
      port_next  = o_port;
      last_next  = o_last;
      load       = 1'b0;
      src        = sel;
      if (out_free)
         valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (out_free && sel_found) begin
               load      = 1'b1;
               src       = sel;
               gnt_next  = sel;
               cnt_next  = 4'd1;
               idle_next = 8'd0;
               if (slot_last_reg[sel] || MAX_BURST == 1) begin
                  last_next = 1'b1;
                  ptr_next  = sel;
               end else begin
                  last_next  = 1'b0;
                  state_next = BURST;
               end
            end
         end
         BURST: begin
            if (out_free && full_reg[gnt_reg]) begin
               load      = 1'b1;
               src       = gnt_reg;
               cnt_next  = cnt_reg + 4'd1;
               idle_next = 8'd0;
               if (slot_last_reg[gnt_reg] || (cnt_reg + 4'd1) == 4'(MAX_BURST)) begin
                  last_next  = 1'b1;
                  ptr_next   = gnt_reg;
                  state_next = IDLE;
               end else begin
                  last_next = 1'b0;
               end
            end else if (!full_reg[gnt_reg]) begin
               // Holder went quiet: release without emitting a closing beat.
               idle_next = idle_reg + 8'd1;
               if (idle_reg == 8'(HOLD_TIMEOUT - 1)) begin
                  idle_next  = 8'd0;
                  ptr_next   = gnt_reg;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (load) begin
         valid_next = 1'b1;
         data_next  = slot_data_reg[src];
         port_next  = src;
      end
   end

   // Accept and drain can never coincide on one slot: accept needs it empty, drain needs it full.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_slot
      assign full_next[gi] = (i_valid[gi] && !full_reg[gi]) ? 1'b1 :
                             (load && src == PW'(gi))       ? 1'b0 : full_reg[gi];
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (i_valid[p] && !full_reg[p]) begin
            slot_data_reg[p] <= i_data[p*DATA_WIDTH +: DATA_WIDTH];
            slot_last_reg[p] <= i_last[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
         ptr_reg   <= PW'(NUM_PORTS - 1);
         gnt_reg   <= '0;
         cnt_reg   <= '0;
         idle_reg  <= '0;
         full_reg  <= '0;
         o_valid   <= 1'b0;
         o_data    <= '0;
         o_port    <= '0;
         o_last    <= 1'b0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         gnt_reg   <= gnt_next;
         cnt_reg   <= cnt_next;
         idle_reg  <= idle_next;
         full_reg  <= full_next;
         o_valid   <= valid_next;
         o_data    <= data_next;
         o_port    <= port_next;
         o_last    <= last_next;
      end
   end
endmodule
